// File: rtl/fifo_share_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_share_pkg
// Description : Shared constants and helpers for the shared-FIFO front end.
//               NUM_REQ       - number of producers sharing the FIFO
//               REQ_IDX_WIDTH - width of a requester index (clog2(NUM_REQ))
//               DATA_WIDTH    - word width, equal to the FIFO's STACK_WIDTH
//               CNT_WIDTH     - width of the accepted-word counter
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_share_pkg;

  localparam int NUM_REQ       = 4;
  localparam int REQ_IDX_WIDTH = 2;
  localparam int DATA_WIDTH    = 32;
  localparam int CNT_WIDTH     = 16;

  // Round-robin successor of a requester index, wrapping at NUM_REQ.
  function automatic logic [REQ_IDX_WIDTH-1:0] next_rr_index(
    input logic [REQ_IDX_WIDTH-1:0] ptr
  );
    if (int'(ptr) == NUM_REQ - 1) begin
      return '0;
    end
    return ptr + REQ_IDX_WIDTH'(1);
  endfunction

endpackage : fifo_share_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. Grants the first set request starting at
//               the rotating pointer; the pointer moves past the winner.
// Ports       : clk     in  clock
//               rst     in  asynchronous active-high reset (pointer -> 0)
//               req     in  per-requester request vector
//               enable  in  resource can take a transfer this cycle
//               gnt     out one-hot grant, or zero
//               gnt_idx out index of the granted requester (0 when none)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import fifo_share_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic                     enable,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [REQ_IDX_WIDTH-1:0] gnt_idx
);

  logic [REQ_IDX_WIDTH-1:0] rr_ptr_q;
  logic [REQ_IDX_WIDTH-1:0] rr_ptr_d;
  logic [REQ_IDX_WIDTH-1:0] cand;
  logic                     found;

  // Scan requesters in priority order rr_ptr, rr_ptr+1, ... and stop at the
  // first one set; 'found' blocks any later candidate from also winning.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    cand     = '0;
    rr_ptr_d = rr_ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = REQ_IDX_WIDTH'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (enable && !found && req[cand]) begin
        found      = 1'b1;
        gnt[cand]  = 1'b1;
        gnt_idx    = cand;
      end
    end
    if (found) begin
      rr_ptr_d = next_rr_index(gnt_idx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/fifo_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_share_ctrl
// Description : Shares one FIFO between NUM_REQ producers (round-robin write
//               arbitration) and turns FIFO reads into a valid/ready stream
//               with one output stage. Never writes a full FIFO and never
//               reads an empty one.
// Ports       : clk, rst               clock, async active-high reset
//               req, req_data          producer requests and packed data
//               gnt                    one-hot grant (combinational)
//               fifo_write/fifo_wdata  FIFO write_to_stack / data_in
//               fifo_read/fifo_rdata   FIFO read_from_stack / data_out
//               fifo_full/fifo_empty   FIFO stack_full / stack_empty
//               out_valid/out_data/out_ready  output stream
//               words_accepted         FIFO writes since reset (wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_share_ctrl
  import fifo_share_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_write,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic                          fifo_read,
  input  logic [DATA_WIDTH-1:0]         fifo_rdata,
  input  logic                          fifo_full,
  input  logic                          fifo_empty,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_ready,
  output logic [CNT_WIDTH-1:0]          words_accepted
);

  logic                     arb_enable;
  logic [REQ_IDX_WIDTH-1:0] gnt_idx;

  logic                     out_valid_q;
  logic                     out_valid_d;
  logic [CNT_WIDTH-1:0]     words_accepted_q;
  logic [CNT_WIDTH-1:0]     words_accepted_d;

  // Reset is folded into the enable so no grant can escape while rst is high.
  assign arb_enable = !fifo_full && !rst;

  rr_arbiter u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .enable  (arb_enable),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign fifo_write = |gnt;

  always_comb begin
    fifo_wdata = '0;
    if (fifo_write) begin
      fifo_wdata = req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Pull a word only when the output stage is empty or being emptied this
  // cycle; this keeps out_data (the FIFO's registered data_out) stable while
  // the consumer stalls.
  assign fifo_read = !rst && !fifo_empty && (!out_valid_q || out_ready);

  always_comb begin
    out_valid_d      = fifo_read || (out_valid_q && !out_ready);
    words_accepted_d = words_accepted_q + CNT_WIDTH'(fifo_write);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q      <= 1'b0;
      words_accepted_q <= '0;
    end else begin
      out_valid_q      <= out_valid_d;
      words_accepted_q <= words_accepted_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = fifo_rdata;
  assign words_accepted = words_accepted_q;

endmodule : fifo_share_ctrl
`default_nettype wire

// File: tb/tb_fifo_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_share_ctrl
// Description : Directed self-checking bench for fifo_share_ctrl, with a
//               depth-8 FIFO model (registered data_out) beside the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_share_ctrl;

  localparam int NREQ  = 4;
  localparam int DW    = 32;
  localparam int CW    = 16;
  localparam int DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*DW-1:0]   req_data = '0;
  logic [NREQ-1:0]      gnt;
  logic                 fifo_write;
  logic [DW-1:0]        fifo_wdata;
  logic                 fifo_read;
  logic [DW-1:0]        fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 out_valid;
  logic [DW-1:0]        out_data;
  logic                 out_ready = 1'b0;
  logic [CW-1:0]        words_accepted;

  int checks   = 0;
  int failures = 0;
  int seq [NREQ];
  int n_out;

  always #5 clk = ~clk;

  fifo_share_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_data       (req_data),
    .gnt            (gnt),
    .fifo_write     (fifo_write),
    .fifo_wdata     (fifo_wdata),
    .fifo_read      (fifo_read),
    .fifo_rdata     (fifo_rdata),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .words_accepted (words_accepted)
  );

  // FIFO model: depth 8, data_out registered on a read.
  logic [DW-1:0] mem [DEPTH];
  int            cnt;
  int            wr_ptr;
  int            rd_ptr;

  assign fifo_full  = (cnt == DEPTH);
  assign fifo_empty = (cnt == 0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 0;
      wr_ptr     <= 0;
      rd_ptr     <= 0;
      fifo_rdata <= '0;
    end else begin
      if (fifo_write && cnt < DEPTH) begin
        mem[wr_ptr] <= fifo_wdata;
        wr_ptr      <= (wr_ptr + 1) % DEPTH;
      end
      if (fifo_read && cnt > 0) begin
        fifo_rdata <= mem[rd_ptr];
        rd_ptr     <= (rd_ptr + 1) % DEPTH;
      end
      cnt <= cnt + ((fifo_write && cnt < DEPTH) ? 1 : 0)
                 - ((fifo_read && cnt > 0) ? 1 : 0);
    end
  end

  // Word presented by producer p on its s-th transfer.
  function automatic logic [DW-1:0] mk(input int p, input int s);
    return 32'hD000_0000 | DW'(p << 16) | DW'(s);
  endfunction

  task automatic drive_data();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = mk(i, seq[i]);
  endtask

  // Advance to the next negedge; granted producers move to their next word.
  task automatic tick();
    logic [NREQ-1:0] g;
    g = gnt;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) if (g[i]) seq[i]++;
    drive_data();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    out_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) seq[i] = 0;
    drive_data();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'hF;
    #1;
    checks++; if (gnt !== 4'h0) begin failures++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++; if (fifo_write !== 1'b0) begin failures++; $display("FAIL reset_fifo_write: got %b expected 0", fifo_write); end
    checks++; if (fifo_read !== 1'b0) begin failures++; $display("FAIL reset_fifo_read: got %b expected 0", fifo_read); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (words_accepted !== 16'd0) begin failures++; $display("FAIL reset_words: got %0d expected 0", words_accepted); end
  endtask

  task automatic test_single_producer();
    logic [NREQ-1:0] exp_g [6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    logic            exp_v [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [DW-1:0]   exp_d [6] = '{32'h0, 32'h0, 32'hA1, 32'hA2, 32'hA3, 32'h0};
    logic [DW-1:0]   din   [3] = '{32'hA1, 32'hA2, 32'hA3};
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      req = (c < 3) ? 4'b0100 : 4'b0000;
      if (c < 3) req_data[2*DW +: DW] = din[c];
      #1;
      checks++; if (gnt !== exp_g[c]) begin failures++; $display("FAIL single_gnt[%0d]: got %b expected %b", c, gnt, exp_g[c]); end
      checks++; if (out_valid !== exp_v[c]) begin failures++; $display("FAIL single_valid[%0d]: got %b expected %b", c, out_valid, exp_v[c]); end
      if (exp_v[c]) begin
        checks++; if (out_data !== exp_d[c]) begin failures++; $display("FAIL single_data[%0d]: got %h expected %h", c, out_data, exp_d[c]); end
      end
      tick();
    end
    #1;
    checks++; if (words_accepted !== 16'd3) begin failures++; $display("FAIL single_words: got %0d expected 3", words_accepted); end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_a [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [NREQ-1:0] exp_b [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000};
    do_reset();
    out_ready = 1'b1;
    req = 4'hF;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++; if (gnt !== exp_a[c]) begin failures++; $display("FAIL rr_all[%0d]: got %b expected %b", c, gnt, exp_a[c]); end
      tick();
    end
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      req = (c < 2) ? 4'b1111 : 4'b1101;
      #1;
      checks++; if (gnt !== exp_b[c]) begin failures++; $display("FAIL rr_drop1[%0d]: got %b expected %b", c, gnt, exp_b[c]); end
      tick();
    end
  endtask

  task automatic test_fill_to_full();
    do_reset();
    out_ready = 1'b0;
    req = 4'hF;
    for (int c = 0; c < 9; c++) begin
      #1;
      checks++; if (gnt !== 4'(1 << (c % 4))) begin failures++; $display("FAIL fill_gnt[%0d]: got %b expected %b", c, gnt, 4'(1 << (c % 4))); end
      tick();
    end
    #1;
    checks++; if (fifo_full !== 1'b1) begin failures++; $display("FAIL fill_full: got %b expected 1", fifo_full); end
    checks++; if (gnt !== 4'h0) begin failures++; $display("FAIL fill_gnt_full: got %b expected 0000", gnt); end
    checks++; if (fifo_read !== 1'b0) begin failures++; $display("FAIL fill_read: got %b expected 0", fifo_read); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fill_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== mk(0, 0)) begin failures++; $display("FAIL fill_data: got %h expected %h", out_data, mk(0, 0)); end
    checks++; if (words_accepted !== 16'd9) begin failures++; $display("FAIL fill_words: got %0d expected 9", words_accepted); end
  endtask

  // Continues from the full state; words leave in global grant order, so the
  // n-th word out is producer n%4's (n/4)-th word.
  task automatic test_drain();
    n_out = 0;
    out_ready = 1'b1;
    #1;
    checks++; if (fifo_read !== 1'b1) begin failures++; $display("FAIL drain_first_read: got %b expected 1", fifo_read); end
    checks++; if (fifo_write !== 1'b0) begin failures++; $display("FAIL drain_first_write: got %b expected 0", fifo_write); end
    checks++; if (out_data !== mk(0, 0)) begin failures++; $display("FAIL drain_data[0]: got %h expected %h", out_data, mk(0, 0)); end
    n_out = 1;
    tick();
    for (int c = 0; c < 16; c++) begin
      #1;
      checks++; if ({fifo_write, fifo_read} !== 2'b11) begin failures++; $display("FAIL drain_wr_rd[%0d]: got %b expected 11", c, {fifo_write, fifo_read}); end
      checks++; if (out_valid !== 1'b1 || out_data !== mk(n_out % 4, n_out / 4)) begin
        failures++; $display("FAIL drain_data[%0d]: got v=%b %h expected v=1 %h", n_out, out_valid, out_data, mk(n_out % 4, n_out / 4));
      end
      n_out++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    held = mk(n_out % 4, n_out / 4);
    out_ready = 1'b0;
    req = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== held) begin failures++; $display("FAIL bp_data[%0d]: got v=%b %h expected v=1 %h", c, out_valid, out_data, held); end
      checks++; if (fifo_read !== 1'b0 || gnt !== 4'h0) begin failures++; $display("FAIL bp_idle[%0d]: got read=%b gnt=%b expected 0/0000", c, fifo_read, gnt); end
      checks++; if (cnt !== 7) begin failures++; $display("FAIL bp_occupancy[%0d]: got %0d expected 7", c, cnt); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (fifo_read !== 1'b1) begin failures++; $display("FAIL bp_release_read: got %b expected 1", fifo_read); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [NREQ-1:0] exp_g [4] = '{4'b0010, 4'b0100, 4'b0010, 4'b0100};
    do_reset();
    out_ready = 1'b0;
    req = 4'b0110;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (gnt !== exp_g[c]) begin failures++; $display("FAIL mid_fill_gnt[%0d]: got %b expected %b", c, gnt, exp_g[c]); end
      tick();
    end
    #1;
    checks++; if (cnt !== 3 || out_valid !== 1'b1) begin failures++; $display("FAIL mid_buffered: got cnt=%0d v=%b expected 3/1", cnt, out_valid); end
    req = 4'b1010;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
    checks++; if (gnt !== 4'h0 || fifo_read !== 1'b0) begin failures++; $display("FAIL mid_rst_gnt: got gnt=%b read=%b expected 0000/0", gnt, fifo_read); end
    checks++; if (words_accepted !== 16'd0) begin failures++; $display("FAIL mid_rst_words: got %0d expected 0", words_accepted); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL mid_first_gnt: got %b expected 0010", gnt); end
    tick();
    #1;
    checks++; if (words_accepted !== 16'd1) begin failures++; $display("FAIL mid_words_after: got %0d expected 1", words_accepted); end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) seq[i] = 0;
    n_out = 0;
    test_reset();
    test_single_producer();
    test_round_robin();
    test_fill_to_full();
    test_drain();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fifo_share_ctrl
`default_nettype wire

// File: doc/fifo_share_ctrl.md
Name: fifo_share_ctrl

Overview:
- Shares one FIFO_Buffer between NUM_REQ producers using a round-robin write arbiter.
- Sequences FIFO reads into a valid/ready output stream with one output register stage.
- Sits directly beside the FIFO instance. The FIFO's write_to_stack/data_in/read_from_stack/data_out/stack_full/stack_empty connect to the fifo_* ports below.
- Guarantees the FIFO never sees a request it would silently drop.

Parameters:
- NUM_REQ, 4, number of producers.
- REQ_IDX_WIDTH, 2, width of a requester index; must equal clog2(NUM_REQ).
- DATA_WIDTH, 32, word width; equals the FIFO's STACK_WIDTH.
- CNT_WIDTH, 16, width of the accepted-word counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req  in  NUM_REQ  per-producer request. Producer i holds req[i] and its data stable until gnt[i].
- req_data  in  NUM_REQ*DATA_WIDTH  producer i's data in bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  out  NUM_REQ  one-hot or zero, combinational. gnt[i]=1 means producer i's word is written at this edge.
- fifo_write  out  1  drives FIFO write_to_stack.
- fifo_wdata  out  DATA_WIDTH  drives FIFO data_in; the granted producer's data, 0 when no grant.
- fifo_read  out  1  drives FIFO read_from_stack.
- fifo_rdata  in  DATA_WIDTH  from FIFO data_out (registered in the FIFO, valid the cycle after a read).
- fifo_full  in  1  FIFO stack_full.
- fifo_empty  in  1  FIFO stack_empty.
- out_valid  out  1  output word valid.
- out_data  out  DATA_WIDTH  output word, equal to fifo_rdata.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- words_accepted  out  CNT_WIDTH  count of FIFO writes since reset; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
  - On reset: rr_ptr=0, out_valid=0, words_accepted=0.
  - While rst=1, gnt, fifo_write and fifo_read are forced to 0.
  - The FIFO shares the same rst.
- Write arbitration (combinational):
  - If fifo_full=1, or no req bit is set: gnt=0 and fifo_write=0.
  - Otherwise, grant the first set req[k] searching k = rr_ptr, rr_ptr+1, … modulo NUM_REQ. Then gnt[k]=1, fifo_write=1, fifo_wdata=req_data slice k.
- Pointer update: on a grant to k, rr_ptr <= (k+1) mod NUM_REQ at the edge; otherwise rr_ptr holds.
- Fairness bound: a continuously requesting producer is granted within NUM_REQ non-full cycles.
- words_accepted increments by 1 on every edge where fifo_write=1.
- Read sequencing:
  - fifo_read = !fifo_empty && (!out_valid || out_ready).
  - At each edge: out_valid <= fifo_read ? 1 : (out_valid && !out_ready) ? 1 : 0.
- Read latency: 1 cycle from fifo_read to out_valid. Sustained throughput is 1 word/cycle.
- Output hold: out_data is the FIFO's registered data_out. It stays stable while out_valid && !out_ready, because no read is issued in that state.
- FIFO boundary rules:
  - Full: the controller never asserts a write, so the FIFO's "full: read only" case never drops data.
  - Empty: the controller never asserts a read, so its "empty: write only" case never applies.
  - Simultaneous write and read when neither full nor empty is allowed and performs both.
- Capacity: total buffering is STACK_HEIGHT words plus 1 (the output stage).
- Reset mid-operation:
  - Words in flight are discarded; out_valid drops asynchronously.
  - A producer holding req re-arbitrates from rr_ptr=0 after reset release.

Decomposition:
- Package fifo_share_pkg holds:
  - the constants NUM_REQ, DATA_WIDTH, REQ_IDX_WIDTH, CNT_WIDTH;
  - a function next_rr_index(ptr) returning (ptr+1) mod NUM_REQ.
- One sub-module, rr_arbiter:
  - Inputs: req, enable (= !fifo_full && !rst). Outputs: one-hot gnt and gnt_idx.
  - Owns rr_ptr and is reusable for other shared resources.
- Read sequencing, the data mux and the counter stay in fifo_share_ctrl.

Test Plan:
- Single producer: req[2]=1 with data 0xA1, 0xA2, 0xA3, out_ready=1, FIFO empty → gnt[2] on 3 consecutive cycles. out_valid shows 0xA1, 0xA2, 0xA3 in order, each first seen 2 cycles after its grant. words_accepted=3.
- Round-robin: all req=1 from reset, out_ready=1, FIFO not full → grant order 0,1,2,3,0,1. req[1] dropped after first grant → order 0,1,2,3,0,2,3.
- Fill to full: all req=1, out_ready=0, depth-8 FIFO → exactly 9 grants (1 word moves to the output stage). Then fifo_full=1, gnt=0, fifo_read=0, and out_data holds the first word.
- Drain from full: from the previous state, raise out_ready=1 → first cycle fifo_read=1 with fifo_write=0. From the next cycle, one write and one read per cycle; no word is lost or duplicated (scoreboard sequence).
- Backpressure: out_valid=1, out_ready=0 for 5 cycles → out_data unchanged, fifo_read=0, FIFO occupancy unchanged.
- Reset mid-stream: assert rst for one cycle with 4 words buffered → out_valid=0 and gnt=0 immediately. words_accepted=0. After release, the first grant goes to the lowest set req index.
